// File: rtl/alu_station_pkg.sv
// Shared types, tag and op-code constants, and the operand snoop helper for alu_station.
package alu_station_pkg;

  localparam int unsigned WORD_W    = 32;
  localparam int unsigned ADDR_W    = 32;
  localparam int unsigned REGADDR_W = 5;
  localparam int unsigned TAG_W     = 2;
  localparam int unsigned OP_W      = 4;
  localparam int unsigned SHAMT_W   = 5;

  typedef logic [WORD_W-1:0]    word_t;
  typedef logic [ADDR_W-1:0]    addr_t;
  typedef logic [REGADDR_W-1:0] regaddr_t;
  typedef logic [TAG_W-1:0]     regtag_t;
  typedef logic [OP_W-1:0]      sinst_t;

  // Producer tags; UNLOCKED marks an operand whose data is already valid.
  localparam regtag_t UNLOCKED   = 2'd0;
  localparam regtag_t ALU_MASTER = 2'd1;
  localparam regtag_t ALU_SALVER = 2'd2;
  localparam regtag_t LOAD_STORE = 2'd3;

  localparam sinst_t OP_ADD   = 4'h0;
  localparam sinst_t OP_SUB   = 4'h1;
  localparam sinst_t OP_SLL   = 4'h2;
  localparam sinst_t OP_SLT   = 4'h3;
  localparam sinst_t OP_SLTU  = 4'h4;
  localparam sinst_t OP_XOR   = 4'h5;
  localparam sinst_t OP_SRL   = 4'h6;
  localparam sinst_t OP_SRA   = 4'h7;
  localparam sinst_t OP_OR    = 4'h8;
  localparam sinst_t OP_AND   = 4'h9;
  localparam sinst_t OP_LUI   = 4'hA;
  localparam sinst_t OP_AUIPC = 4'hB;
  localparam sinst_t OP_LINK  = 4'hC;

  // Register write-bus payload (WRITE_VAR_DEFINE): strobe, destination register, data.
  typedef struct packed {
    logic     en;
    regaddr_t addr;
    word_t    data;
  } write_bus_t;

  // A source operand as held by the station: pending tag plus data.
  typedef struct packed {
    regtag_t tag;
    word_t   data;
  } operand_t;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // Resolve a pending operand against the three write buses by producer tag.
  function automatic operand_t snoop_operand(
    input operand_t opnd,
    input logic     en0,
    input word_t    data0,
    input logic     en1,
    input word_t    data1,
    input logic     enm,
    input word_t    datam
  );
    operand_t res;
    res = opnd;
    if (opnd.tag == ALU_MASTER && en0) begin
      res.tag  = UNLOCKED;
      res.data = data0;
    end else if (opnd.tag == ALU_SALVER && en1) begin
      res.tag  = UNLOCKED;
      res.data = data1;
    end else if (opnd.tag == LOAD_STORE && enm) begin
      res.tag  = UNLOCKED;
      res.data = datam;
    end
    return res;
  endfunction

endpackage

// File: rtl/alu_station_alu_core.sv
// alu_core: purely combinational integer ALU shared by the WAIT and fast-issue paths.
module alu_core
  import alu_station_pkg::*;
(
  input  sinst_t op,
  input  word_t  x,
  input  word_t  y,
  input  addr_t  pc,
  output word_t  result_c
);

  logic [SHAMT_W-1:0] shamt;
  assign shamt = y[SHAMT_W-1:0];

  // Op-code decode; unassigned codes yield zero.
  always_comb begin
    result_c = '0;
    case (op)
      OP_ADD:   result_c = x + y;
      OP_SUB:   result_c = x - y;
      OP_SLL:   result_c = x << shamt;
      OP_SLT:   result_c = WORD_W'($signed(x) < $signed(y));
      OP_SLTU:  result_c = WORD_W'(x < y);
      OP_XOR:   result_c = x ^ y;
      OP_SRL:   result_c = x >> shamt;
      OP_SRA:   result_c = word_t'($signed(x) >>> shamt);
      OP_OR:    result_c = x | y;
      OP_AND:   result_c = x & y;
      OP_LUI:   result_c = y;
      OP_AUIPC: result_c = word_t'(pc + y);
      OP_LINK:  result_c = word_t'(pc + ADDR_W'(4));
      default:  result_c = '0;
    endcase
  end

endmodule

// File: rtl/alu_station.sv
// alu_station: single-entry reservation station with integer ALU and write-bus snooping.
// Optional macro ALU_STATION_FAST_EN: operands ready at issue execute on the accept edge.
module alu_station
  import alu_station_pkg::*;
#(
  parameter regtag_t SELF_TAG = ALU_MASTER
) (
  input  logic     clk,
  input  logic     rst,
  input  logic     en_in,
  input  addr_t    pc_in,
  input  sinst_t   op_in,
  input  regtag_t  tagx_in,
  input  regtag_t  tagy_in,
  input  word_t    datax_in,
  input  word_t    datay_in,
  input  regtag_t  tagw_in,
  input  regaddr_t addrw_in,
  input  logic     en_mw0,
  input  regaddr_t reg_write_addr0,
  input  word_t    write_data0,
  input  logic     en_mw1,
  input  regaddr_t reg_write_addr1,
  input  word_t    write_data1,
  input  logic     en_mwM,
  input  regaddr_t reg_write_addrM,
  input  word_t    write_dataM,
  output logic     busy_out,
  output logic     en_mw_out,
  output regaddr_t reg_write_addr_out,
  output word_t    write_data_out
);

  state_t     state, state_n;
  addr_t      pc_q, pc_n;
  sinst_t     op_q, op_n;
  operand_t   opx_q, opx_n, opy_q, opy_n;
  regtag_t    tagw_q, tagw_n;
  regaddr_t   addrw_n;
  word_t      data_n;
  logic       accept;
  logic       core_from_issue;
  sinst_t     core_op;
  word_t      core_x, core_y, core_result;
  addr_t      core_pc;
  write_bus_t bus0, bus1, busm;

  assign bus0 = '{en: en_mw0, addr: reg_write_addr0, data: write_data0};
  assign bus1 = '{en: en_mw1, addr: reg_write_addr1, data: write_data1};
  assign busm = '{en: en_mwM, addr: reg_write_addrM, data: write_dataM};

  // Bus register addresses, the destination tag and our own tag belong to the
  // register file / allocator; the station itself matches producers by tag only.
  logic unused_fields;
  assign unused_fields = ^{bus0.addr, bus1.addr, busm.addr, tagw_q, SELF_TAG};

  // Issue is ignored while busy; no snoop happens on the accept edge itself.
  assign accept = en_in && (state != S_WAIT);

`ifdef ALU_STATION_FAST_EN
  // Accepting cycles compute from the issue inputs; WAIT computes from the held operands.
  assign core_from_issue = (state != S_WAIT);
`else
  assign core_from_issue = 1'b0;
`endif

  assign core_op = core_from_issue ? op_in    : op_q;
  assign core_x  = core_from_issue ? datax_in : opx_q.data;
  assign core_y  = core_from_issue ? datay_in : opy_q.data;
  assign core_pc = core_from_issue ? pc_in    : pc_q;

  alu_core u_alu_core (
    .op       (core_op),
    .x        (core_x),
    .y        (core_y),
    .pc       (core_pc),
    .result_c (core_result)
  );

  // Next-state, operand snoop/latch and result selection.
  always_comb begin
    state_n = state;
    pc_n    = pc_q;
    op_n    = op_q;
    opx_n   = opx_q;
    opy_n   = opy_q;
    tagw_n  = tagw_q;
    addrw_n = reg_write_addr_out;
    data_n  = write_data_out;

    case (state)
      S_IDLE: state_n = S_IDLE;
      S_WAIT: begin
        if (opx_q.tag == UNLOCKED && opy_q.tag == UNLOCKED) begin
          data_n  = core_result;
          state_n = S_DONE;
        end else begin
          opx_n = snoop_operand(opx_q, bus0.en, bus0.data, bus1.en, bus1.data,
                                busm.en, busm.data);
          opy_n = snoop_operand(opy_q, bus0.en, bus0.data, bus1.en, bus1.data,
                                busm.en, busm.data);
        end
      end
      S_DONE:  state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase

    if (accept) begin
      pc_n    = pc_in;
      op_n    = op_in;
      opx_n   = '{tag: tagx_in, data: datax_in};
      opy_n   = '{tag: tagy_in, data: datay_in};
      tagw_n  = tagw_in;
      addrw_n = addrw_in;
      state_n = S_WAIT;
`ifdef ALU_STATION_FAST_EN
      if (tagx_in == UNLOCKED && tagy_in == UNLOCKED) begin
        data_n  = core_result;
        state_n = S_DONE;
      end
`endif
    end
  end

  // State, held instruction and registered outputs; reset drops any held instruction.
  always_ff @(posedge clk) begin
    if (rst) begin
      state              <= S_IDLE;
      pc_q               <= '0;
      op_q               <= '0;
      opx_q              <= '{tag: UNLOCKED, data: '0};
      opy_q              <= '{tag: UNLOCKED, data: '0};
      tagw_q             <= UNLOCKED;
      busy_out           <= 1'b0;
      en_mw_out          <= 1'b0;
      reg_write_addr_out <= '0;
      write_data_out     <= '0;
    end else begin
      state              <= state_n;
      pc_q               <= pc_n;
      op_q               <= op_n;
      opx_q              <= opx_n;
      opy_q              <= opy_n;
      tagw_q             <= tagw_n;
      busy_out           <= (state_n == S_WAIT);
      en_mw_out          <= (state_n == S_DONE);
      reg_write_addr_out <= addrw_n;
      write_data_out     <= data_n;
    end
  end

endmodule
